npc_halt_ctrl: RTL and testbench

Sequences simulation termination for the RV64 NPC core. Watches the commit stage for ebreak and an idle-core watchdog. On either event it stalls fetch, waits for in-flight memory and writeback traffic to drain, then halts. It reports a good, bad or timeout trap code plus cycle and retired-instruction counts. It sits beside the commit/writeback stage; its halt_req drives the fetch stall.

---
 rtl/npc_trap_pkg.sv | 18 +
 rtl/npc_watchdog.sv | 33 +++
 rtl/npc_halt_ctrl.sv | 118 +++++++++++
 tb/tb_npc_halt_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_trap_pkg.sv
// Shared types and constants for the NPC simulation-termination controller.
// Optional DPI trap reporting in the top is enabled by defining NPC_DPI_TRAP_EN.
package npc_trap_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_GOOD    = 2'b01;
    localparam logic [1:0] TRAP_BAD     = 2'b10;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b11;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/npc_watchdog.sv
// Idle-core watchdog: counts cycles without a retired instruction, saturating,
// and flags when the count equals a non-zero threshold.
module npc_watchdog
    import npc_trap_pkg::*;
#(
    parameter int TMO_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             count_en,
    input  logic             inst_valid,
    input  logic [TMO_W-1:0] threshold,
    output logic             match
);

    logic [TMO_W-1:0] idle_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (count_en) begin
            if (inst_valid) begin
                idle_cnt <= '0;
            end else if (idle_cnt != '1) begin
                idle_cnt <= idle_cnt + TMO_W'(1);
            end
        end
    end

    // A zero threshold disables the watchdog entirely.
    assign match = (threshold != '0) && (idle_cnt == threshold);

endmodule

// File: rtl/npc_halt_ctrl.sv
// Simulation-termination sequencer: RUN -> DRAIN -> HALT on ebreak or watchdog.
// Define NPC_DPI_TRAP_EN to print the trap result on HALT entry.
module npc_halt_ctrl
    import npc_trap_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int CNT_W     = 64,
    parameter int DRAIN_MAX = 16,
    parameter int TMO_W     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inst_valid,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  a0,
    input  logic             lsu_busy,
    input  logic             wb_pending,
    input  logic [TMO_W-1:0] timeout_cycles,
    output logic             halt_req,
    output logic             halted,
    output logic             trap_valid,
    output logic [1:0]       trap_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int DW = $clog2(DRAIN_MAX + 1);

    state_t          state;
    logic [1:0]      code;
    logic [DW-1:0]   drain_cnt;
    logic            is_ebreak;
    logic            wd_match;
    logic            drained;
    logic            drain_expired;

    assign is_ebreak     = inst_valid && (inst == EBREAK_INST);
    assign drained       = !lsu_busy && !wb_pending;
    assign drain_expired = (drain_cnt == DW'(DRAIN_MAX - 1));

    npc_watchdog #(
        .TMO_W(TMO_W)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .count_en  (state == RUN),
        .inst_valid(inst_valid),
        .threshold (timeout_cycles),
        .match     (wd_match)
    );

    // ebreak takes priority over a coincident watchdog match; in DRAIN the
    // drained check wins over the forced-halt limit in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            code        <= TRAP_NONE;
            drain_cnt   <= '0;
            trap_valid  <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            trap_valid <= 1'b0;
            case (state)
                RUN: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (inst_valid) begin
                        instret_cnt <= instret_cnt + CNT_W'(1);
                    end
                    if (is_ebreak) begin
                        code      <= (a0 == '0) ? TRAP_GOOD : TRAP_BAD;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else if (wd_match) begin
                        code      <= TRAP_TIMEOUT;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (drained) begin
                        state      <= HALT;
                        trap_valid <= 1'b1;
                    end else if (drain_expired) begin
                        state      <= HALT;
                        trap_valid <= 1'b1;
                        code       <= TRAP_TIMEOUT;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                HALT: begin
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign halt_req  = (state != RUN);
    assign halted    = (state == HALT);
    assign trap_code = halted ? code : TRAP_NONE;

`ifdef NPC_DPI_TRAP_EN
    always @(posedge clock) begin
        if (!reset && trap_valid) begin
            case (trap_code)
                TRAP_GOOD: $display("HIT GOOD TRAP");
                TRAP_BAD:  $display("HIT BAD TRAP");
                default:   $display("HIT TIMEOUT");
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_npc_halt_ctrl.sv
// Self-checking bench for npc_halt_ctrl: directed scenarios, a per-cycle
// behavioural model compared on every falling edge, and literal spot checks.
module tb_npc_halt_ctrl;

    localparam int          DRAIN_MAX = 16;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    logic        clock;
    logic        reset;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] a0;
    logic        lsu_busy;
    logic        wb_pending;
    logic [31:0] timeout_cycles;
    logic        halt_req;
    logic        halted;
    logic        trap_valid;
    logic [1:0]  trap_code;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    int checks = 0;
    int errors = 0;

    npc_halt_ctrl #(
        .XLEN     (64),
        .CNT_W    (64),
        .DRAIN_MAX(DRAIN_MAX),
        .TMO_W    (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .a0            (a0),
        .lsu_busy      (lsu_busy),
        .wb_pending    (wb_pending),
        .timeout_cycles(timeout_cycles),
        .halt_req      (halt_req),
        .halted        (halted),
        .trap_valid    (trap_valid),
        .trap_code     (trap_code),
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural model: "stopping" once a termination event is seen,
    // "halted" once the pipe has drained or the drain budget ran out.
    bit              m_stopping = 1'b0;
    bit              m_halted   = 1'b0;
    bit              m_pulse    = 1'b0;
    logic [1:0]      m_code     = 2'd0;
    longint unsigned m_cycles   = 0;
    longint unsigned m_instret  = 0;
    longint unsigned m_idle     = 0;
    int              m_drained_for = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_stopping    <= 1'b0;
            m_halted      <= 1'b0;
            m_pulse       <= 1'b0;
            m_code        <= 2'd0;
            m_cycles      <= 0;
            m_instret     <= 0;
            m_idle        <= 0;
            m_drained_for <= 0;
        end else begin
            m_pulse <= 1'b0;
            if (!m_halted) m_cycles <= m_cycles + 1;
            if (m_stopping && !m_halted) begin
                if (!lsu_busy && !wb_pending) begin
                    m_halted <= 1'b1;
                    m_pulse  <= 1'b1;
                end else if (m_drained_for + 1 >= DRAIN_MAX) begin
                    m_halted <= 1'b1;
                    m_pulse  <= 1'b1;
                    m_code   <= 2'd3;
                end
                m_drained_for <= m_drained_for + 1;
            end else if (!m_stopping) begin
                if (inst_valid) begin
                    m_instret <= m_instret + 1;
                    m_idle    <= 0;
                end else if (m_idle < 64'hFFFF_FFFF) begin
                    m_idle <= m_idle + 1;
                end
                if (inst_valid && inst == EBREAK) begin
                    m_stopping <= 1'b1;
                    m_code     <= (a0 == 64'd0) ? 2'd1 : 2'd2;
                end else if (timeout_cycles != 0 && m_idle == 64'(timeout_cycles)) begin
                    m_stopping <= 1'b1;
                    m_code     <= 2'd3;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        checkOutput("model_halt_req", 64'(halt_req), 64'(m_stopping));
        checkOutput("model_halted", 64'(halted), 64'(m_halted));
        checkOutput("model_trap_valid", 64'(trap_valid), 64'(m_pulse));
        checkOutput("model_trap_code", 64'(trap_code), m_halted ? 64'(m_code) : 64'd0);
        checkOutput("model_cycle_cnt", cycle_cnt, m_cycles);
        checkOutput("model_instret_cnt", instret_cnt, m_instret);
    end

    // Drive one cycle's inputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [63:0] a,
                                 input logic l, input logic w);
        inst_valid = v;
        inst       = i;
        a0         = a;
        lsu_busy   = l;
        wb_pending = w;
        @(posedge clock);
        #1;
    endtask

    task automatic resetDut(input logic [31:0] tmo);
        reset          = 1'b1;
        timeout_cycles = tmo;
        inst_valid     = 1'b0;
        inst           = NOP;
        a0             = '0;
        lsu_busy       = 1'b0;
        wb_pending     = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;

        $display("[TB] good trap, drained pipe, ebreak at cycle 10");
        resetDut(32'd0);
        checkOutput("rst_halt_req", 64'(halt_req), 64'd0);
        checkOutput("rst_cycle_cnt", cycle_cnt, 64'd0);
        for (int k = 0; k < 10; k++) applyStimulus(k >= 2 && k <= 5, NOP, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, EBREAK, 64'd0, 1'b0, 1'b0);
        checkOutput("t1_halt_req_n1", 64'(halt_req), 64'd1);
        checkOutput("t1_halted_n1", 64'(halted), 64'd0);
        applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        checkOutput("t1_trap_valid", 64'(trap_valid), 64'd1);
        checkOutput("t1_trap_code", 64'(trap_code), 64'd1);
        checkOutput("t1_cycle_cnt", cycle_cnt, 64'd12);
        checkOutput("t1_instret", instret_cnt, 64'd5);
        applyStimulus(1'b1, NOP, 64'd0, 1'b0, 1'b0);
        checkOutput("t1_pulse_end", 64'(trap_valid), 64'd0);
        checkOutput("t1_cycle_frozen", cycle_cnt, 64'd12);
        checkOutput("t1_instret_frozen", instret_cnt, 64'd5);

        $display("[TB] bad trap with three cycles of writeback drain");
        resetDut(32'd0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, EBREAK, 64'd5, 1'b0, 1'b1);
        applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b1);
        checkOutput("t2_halted_early", 64'(halted), 64'd0);
        applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        checkOutput("t2_trap_valid", 64'(trap_valid), 64'd1);
        checkOutput("t2_trap_code", 64'(trap_code), 64'd2);
        checkOutput("t2_cycle_cnt", cycle_cnt, 64'd7);

        $display("[TB] watchdog at 20 idle cycles");
        resetDut(32'd20);
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        checkOutput("t3_no_req_at_20", 64'(halt_req), 64'd0);
        applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        checkOutput("t3_req_at_21", 64'(halt_req), 64'd1);
        applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        checkOutput("t3_halted", 64'(halted), 64'd1);
        checkOutput("t3_trap_code", 64'(trap_code), 64'd3);
        checkOutput("t3_cycle_cnt", cycle_cnt, 64'd22);

        $display("[TB] watchdog disabled");
        resetDut(32'd0);
        for (int k = 0; k < 60; k++) applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        checkOutput("t3b_halt_req", 64'(halt_req), 64'd0);
        checkOutput("t3b_cycle_cnt", cycle_cnt, 64'd60);

        $display("[TB] stuck lsu forces timeout after drain limit");
        resetDut(32'd0);
        for (int k = 0; k < 2; k++) applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, EBREAK, 64'd0, 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) applyStimulus(1'b0, NOP, 64'd0, 1'b1, 1'b0);
        checkOutput("t4_halted_early", 64'(halted), 64'd0);
        applyStimulus(1'b0, NOP, 64'd0, 1'b1, 1'b0);
        checkOutput("t4_halted", 64'(halted), 64'd1);
        checkOutput("t4_trap_code", 64'(trap_code), 64'd3);
        checkOutput("t4_cycle_cnt", cycle_cnt, 64'd19);

        $display("[TB] ebreak coincident with watchdog, ebreaks ignored in drain");
        resetDut(32'd5);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, EBREAK, 64'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, EBREAK, 64'd7, 1'b1, 1'b0);
        applyStimulus(1'b1, EBREAK, 64'd7, 1'b1, 1'b0);
        applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        checkOutput("t5_trap_valid", 64'(trap_valid), 64'd1);
        checkOutput("t5_trap_code", 64'(trap_code), 64'd1);
        checkOutput("t5_instret", instret_cnt, 64'd1);

        $display("[TB] asynchronous reset in drain");
        resetDut(32'd0);
        for (int k = 0; k < 2; k++) applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, EBREAK, 64'd0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) applyStimulus(1'b0, NOP, 64'd0, 1'b1, 1'b0);
        checkOutput("t6_in_drain", 64'(halt_req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_halt_req", 64'(halt_req), 64'd0);
        checkOutput("t6_rst_cycle_cnt", cycle_cnt, 64'd0);
        checkOutput("t6_rst_instret", instret_cnt, 64'd0);
        inst_valid = 1'b0;
        lsu_busy   = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, NOP, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, NOP, 64'd0, 1'b0, 1'b0);
        checkOutput("t6_cycle_restart", cycle_cnt, 64'd4);
        checkOutput("t6_instret_restart", instret_cnt, 64'd1);
        checkOutput("t6_running", 64'(halt_req), 64'd0);

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
